// File: rtl/mips_exec_ctrl.sv
// -----------------------------------------------------------------------------
// mips_exec_ctrl
//   Multi-cycle execute controller for a small MIPS subset. It accepts one
//   instruction word per handshake, decodes it into register-file addresses,
//   immediate data, operand-mux select and ALU op code, waits one cycle for the
//   datapath to settle, then retires it with a write-enable / done pulse.
//   Sequence per instruction: IDLE -> DECODE -> EXEC -> WB -> IDLE (4 cycles).
//   Unsupported words retire early as IDLE -> DECODE -> IDLE with an illegal
//   pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   instr_valid  instruction word on instr is valid
//   instr[31:0]  MIPS instruction word
//   instr_ready  controller can accept an instruction (IDLE and not in reset)
//   rgAddR1[4:0] register-file read address 1 (rs)
//   rgAddR2[4:0] register-file read address 2 (rt)
//   rgAddW[4:0]  register-file write address
//   Idata[15:0]  immediate field for the operand mux
//   slc          operand mux select (0 = register, 1 = immediate)
//   ctrl[3:0]    ALU operation code
//   ovf          ALU overflow flag, sampled at the edge leaving EXEC
//   reg_wen      register-file write enable (WB only)
//   done         one-cycle retire pulse (WB only)
//   illegal      one-cycle unsupported-instruction pulse
//   ovf_exc      one-cycle arithmetic-overflow pulse (WB only)
// -----------------------------------------------------------------------------
module mips_exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  rgAddR1,
    output logic [4:0]  rgAddR2,
    output logic [4:0]  rgAddW,
    output logic [15:0] Idata,
    output logic        slc,
    output logic [3:0]  ctrl,
    input  logic        ovf,
    output logic        reg_wen,
    output logic        done,
    output logic        illegal,
    output logic        ovf_exc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t      state_r, state_nx_s;
    logic [31:0] ir_r, ir_nx_s;
    logic [4:0]  rgaddr1_r, rgaddr1_nx_s;
    logic [4:0]  rgaddr2_r, rgaddr2_nx_s;
    logic [4:0]  rgaddrw_r, rgaddrw_nx_s;
    logic [15:0] idata_r, idata_nx_s;
    logic        slc_r, slc_nx_s;
    logic [3:0]  ctrl_r, ctrl_nx_s;
    logic        reg_wen_r, reg_wen_nx_s;
    logic        done_r, done_nx_s;
    logic        illegal_r, illegal_nx_s;
    logic        ovf_exc_r, ovf_exc_nx_s;
    logic [4:0]  dec_s;       // {legal, alu op}
    logic        ovf_hit_s;

    // Map an instruction word to {legal, ALU op}; unsupported words give legal=0.
    function automatic logic [4:0] decode_op(input logic [31:0] word);
        logic [4:0] res;
        res = 5'b0_0000;
        if (word[31:26] == 6'h00) begin
            case (word[5:0])
                6'h20:   res = 5'b1_0010;   // add
                6'h22:   res = 5'b1_0110;   // sub
                6'h24:   res = 5'b1_0000;   // and
                6'h25:   res = 5'b1_0001;   // or
                6'h27:   res = 5'b1_1100;   // nor
                6'h2A:   res = 5'b1_0111;   // slt
                default: res = 5'b0_0000;
            endcase
        end else begin
            case (word[31:26])
                6'h08:   res = 5'b1_0010;   // addi
                6'h0C:   res = 5'b1_0000;   // andi
                6'h0D:   res = 5'b1_0001;   // ori
                6'h0A:   res = 5'b1_0111;   // slti
                default: res = 5'b0_0000;
            endcase
        end
        return res;
    endfunction

    // Ready is combinational so it drops in the same cycle rst is raised.
    assign instr_ready = (state_r == IDLE) && !rst;

    assign rgAddR1 = rgaddr1_r;
    assign rgAddR2 = rgaddr2_r;
    assign rgAddW  = rgaddrw_r;
    assign Idata   = idata_r;
    assign slc     = slc_r;
    assign ctrl    = ctrl_r;
    assign reg_wen = reg_wen_r;
    assign done    = done_r;
    assign illegal = illegal_r;
    assign ovf_exc = ovf_exc_r;

    // Next-state, IR capture, decode-field load and retire-pulse generation.
    always_comb begin
        state_nx_s   = state_r;
        ir_nx_s      = ir_r;
        rgaddr1_nx_s = rgaddr1_r;
        rgaddr2_nx_s = rgaddr2_r;
        rgaddrw_nx_s = rgaddrw_r;
        idata_nx_s   = idata_r;
        slc_nx_s     = slc_r;
        ctrl_nx_s    = ctrl_r;
        reg_wen_nx_s = 1'b0;
        done_nx_s    = 1'b0;
        illegal_nx_s = 1'b0;
        ovf_exc_nx_s = 1'b0;
        dec_s        = decode_op(ir_r);
        // Only add/sub/addi map to op 2 or 6, so the op code identifies them.
        ovf_hit_s    = ((ctrl_r == 4'd2) || (ctrl_r == 4'd6)) && ovf;

        case (state_r)
            IDLE: begin
                if (instr_valid) begin
                    ir_nx_s    = instr;
                    state_nx_s = DECODE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DECODE: begin
                if (dec_s[4]) begin
                    rgaddr1_nx_s = ir_r[25:21];
                    rgaddr2_nx_s = ir_r[20:16];
                    ctrl_nx_s    = dec_s[3:0];
                    if (ir_r[31:26] == 6'h00) begin
                        rgaddrw_nx_s = ir_r[15:11];
                        idata_nx_s   = 16'h0000;
                        slc_nx_s     = 1'b0;
                    end else begin
                        rgaddrw_nx_s = ir_r[20:16];
                        idata_nx_s   = ir_r[15:0];
                        slc_nx_s     = 1'b1;
                    end
                    state_nx_s = EXEC;
                end else begin
                    // Decode fields keep their previous values on an illegal word.
                    illegal_nx_s = 1'b1;
                    state_nx_s   = IDLE;
                end
            end
            EXEC: begin
                // Pulses are registered here so they are visible during WB.
                done_nx_s    = 1'b1;
                ovf_exc_nx_s = ovf_hit_s;
                reg_wen_nx_s = !ovf_hit_s && (rgaddrw_r != 5'd0);
                state_nx_s   = WB;
            end
            WB: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ir_r      <= 32'h0000_0000;
            rgaddr1_r <= 5'd0;
            rgaddr2_r <= 5'd0;
            rgaddrw_r <= 5'd0;
            idata_r   <= 16'h0000;
            slc_r     <= 1'b0;
            ctrl_r    <= 4'd0;
            reg_wen_r <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            ovf_exc_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            ir_r      <= ir_nx_s;
            rgaddr1_r <= rgaddr1_nx_s;
            rgaddr2_r <= rgaddr2_nx_s;
            rgaddrw_r <= rgaddrw_nx_s;
            idata_r   <= idata_nx_s;
            slc_r     <= slc_nx_s;
            ctrl_r    <= ctrl_nx_s;
            reg_wen_r <= reg_wen_nx_s;
            done_r    <= done_nx_s;
            illegal_r <= illegal_nx_s;
            ovf_exc_r <= ovf_exc_nx_s;
        end
    end

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_exec_ctrl
//   Scoreboard bench for mips_exec_ctrl. The stimulus process issues directed
//   and random instruction words, computes the expected retirement from the
//   instruction-set rules and pushes it into a queue; a monitor pops and
//   compares whenever done or illegal is presented.
// -----------------------------------------------------------------------------
module tb_mips_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rgAddR1, rgAddR2, rgAddW;
    logic [15:0] Idata;
    logic        slc;
    logic [3:0]  ctrl;
    logic        ovf;
    logic        reg_wen, done, illegal, ovf_exc;

    always #5 clk = ~clk;

    mips_exec_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .rgAddR1(rgAddR1), .rgAddR2(rgAddR2),
        .rgAddW(rgAddW), .Idata(Idata), .slc(slc), .ctrl(ctrl), .ovf(ovf),
        .reg_wen(reg_wen), .done(done), .illegal(illegal), .ovf_exc(ovf_exc)
    );

    typedef struct {
        logic        ill;
        logic [4:0]  a1, a2, aw;
        logic [15:0] imm;
        logic        sel;
        logic [3:0]  op;
        logic        wen;
        logic        oexc;
        int          at;      // cycle index in which the pulse must appear
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   prev_acc = 0;
    logic prev_ill = 1'b0;
    logic prev_ok  = 1'b0;

    logic [5:0] fn_tab [0:5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0] op_tab [0:3] = '{6'h08, 6'h0C, 6'h0D, 6'h0A};

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: what the instruction should do, from the ISA subset rules.
    function automatic exp_t model(input logic [31:0] w, input logic ov, input int acc);
        exp_t e;
        logic arith;
        e.ill = 1'b1; e.a1 = 5'd0; e.a2 = 5'd0; e.aw = 5'd0; e.imm = 16'h0;
        e.sel = 1'b0; e.op = 4'd0; e.wen = 1'b0; e.oexc = 1'b0;
        e.at = acc + 1;
        arith = 1'b0;
        if (w[31:26] == 6'd0) begin
            e.ill = 1'b0;
            case (w[5:0])
                6'h20: begin e.op = 4'd2;  arith = 1'b1; end
                6'h22: begin e.op = 4'd6;  arith = 1'b1; end
                6'h24: e.op = 4'd0;
                6'h25: e.op = 4'd1;
                6'h27: e.op = 4'd12;
                6'h2A: e.op = 4'd7;
                default: e.ill = 1'b1;
            endcase
            e.a1 = w[25:21]; e.a2 = w[20:16]; e.aw = w[15:11];
        end else begin
            e.ill = 1'b0;
            case (w[31:26])
                6'h08: begin e.op = 4'd2; arith = 1'b1; end
                6'h0C: e.op = 4'd0;
                6'h0D: e.op = 4'd1;
                6'h0A: e.op = 4'd7;
                default: e.ill = 1'b1;
            endcase
            e.a1 = w[25:21]; e.a2 = w[20:16]; e.aw = w[20:16];
            e.imm = w[15:0]; e.sel = 1'b1;
        end
        if (!e.ill) begin
            e.at   = acc + 2;
            e.oexc = arith && ov;
            e.wen  = !e.oexc && (e.aw != 5'd0);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom();
        k = $urandom_range(0, 9);
        if (k <= 3) begin
            w[31:26] = 6'd0; w[5:0] = fn_tab[$urandom_range(0, 5)];
        end else if (k <= 6) begin
            w[31:26] = op_tab[$urandom_range(0, 3)];
        end else if (k == 7) begin
            w[31:26] = 6'd0;
        end else if (k == 9) begin
            w[31:26] = 6'd0; w[5:0] = fn_tab[$urandom_range(0, 5)]; w[15:11] = 5'd0;
        end
        return w;
    endfunction

    // Monitor: exclusivity rules every cycle, scoreboard pop on each retirement.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((reg_wen && !done) || (ovf_exc && !done) || (ovf_exc && reg_wen) ||
                (illegal && (done || reg_wen || ovf_exc))) begin
                errors++;
                $display("FAIL excl cyc=%0d got done=%b wen=%b ill=%b oexc=%b, required legal combination",
                         cyc, done, reg_wen, illegal, ovf_exc);
            end
            if (done || illegal) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected cyc=%0d got done=%b ill=%b, required no pulse", cyc, done, illegal);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (illegal !== e.ill || reg_wen !== e.wen || ovf_exc !== e.oexc || cyc != e.at) begin
                        errors++;
                        $display("FAIL retire cyc=%0d got ill=%b wen=%b oexc=%b, required ill=%b wen=%b oexc=%b at cyc=%0d",
                                 cyc, illegal, reg_wen, ovf_exc, e.ill, e.wen, e.oexc, e.at);
                    end
                    if (!e.ill) begin
                        checks++;
                        if (rgAddR1 !== e.a1 || rgAddR2 !== e.a2 || rgAddW !== e.aw ||
                            Idata !== e.imm || slc !== e.sel || ctrl !== e.op) begin
                            errors++;
                            $display("FAIL fields got r1=%0d r2=%0d w=%0d imm=%h slc=%b ctrl=%0d, required r1=%0d r2=%0d w=%0d imm=%h slc=%b ctrl=%0d",
                                     rgAddR1, rgAddR2, rgAddW, Idata, slc, ctrl,
                                     e.a1, e.a2, e.aw, e.imm, e.sel, e.op);
                        end
                    end
                end
            end
        end
    end

    // Issue one instruction; entered and left at a falling edge.
    task automatic issue(input logic [31:0] w, input logic ov, input int gap);
        int n;
        int acc;
        exp_t e;
        repeat (gap) begin instr_valid = 1'b0; @(negedge clk); end
        instr = w; instr_valid = 1'b1; ovf = ~ov;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        if (!instr_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout got ready=0, required ready=1 within 20 cycles");
            instr_valid = 1'b0; prev_ok = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (prev_ok && gap == 0) begin
            checks++;
            if (acc != prev_acc + (prev_ill ? 2 : 4)) begin
                errors++;
                $display("FAIL accept_spacing got %0d, required %0d", acc - prev_acc, prev_ill ? 2 : 4);
            end
        end
        e = model(w, ov, acc);
        sbq.push_back(e);
        prev_acc = acc; prev_ill = e.ill; prev_ok = 1'b1;
        @(negedge clk);                           // DECODE
        instr = $urandom();                       // IR must already hold the word
        if (e.ill) begin
            instr_valid = 1'b0;
        end else begin
            @(negedge clk); ovf = ov;             // EXEC
            @(negedge clk); ovf = ~ov;            // WB
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({rgAddR1, rgAddR2, rgAddW, Idata, slc, ctrl, reg_wen, done, illegal, ovf_exc, instr_ready} !== 47'd0) begin
            errors++;
            $display("FAIL %s got r1=%0d r2=%0d w=%0d imm=%h slc=%b ctrl=%0d wen=%b done=%b ill=%b oexc=%b rdy=%b, required all 0",
                     nm, rgAddR1, rgAddR2, rgAddW, Idata, slc, ctrl, reg_wen, done, illegal, ovf_exc, instr_ready);
        end
    endtask

    task automatic check_ready(input string nm);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s got ready=%b, required 1", nm, instr_ready);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        #1 check_ready("ready_after_reset");
        @(negedge clk);

        issue(32'h014B5020, 1'b0, 0);   // add $t2,$t2,$t3
        issue(32'h214A0005, 1'b0, 0);   // addi $t2,$t2,5
        issue(32'h0319C027, 1'b0, 0);   // nor $t8,$t8,$t9
        issue(32'h0319C027, 1'b0, 0);   // back-to-back
        issue(32'h8D490000, 1'b0, 0);   // lw -> illegal
        issue(32'h014B0020, 1'b0, 0);   // add $0 -> no write
        issue(32'h014B5022, 1'b1, 0);   // sub with overflow
        issue(32'h014B5022, 1'b0, 0);   // sub without overflow
        issue(32'h214A7FFF, 1'b1, 0);   // addi with overflow
        issue(32'h014B5024, 1'b1, 1);   // and ignores overflow
        issue(32'h014B502A, 1'b1, 0);   // slt ignores overflow

        // Abort in EXEC: no retirement may follow.
        @(negedge clk);
        instr = 32'h014B5020; instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk); instr_valid = 1'b0;       // DECODE
        @(negedge clk); rst = 1'b1;               // EXEC
        @(negedge clk);
        check_zero("abort_outputs");
        rst = 1'b0;
        #1 check_ready("abort_ready");
        @(negedge clk);
        prev_ok = 1'b0;

        for (int i = 0; i < 150; i++) begin
            int g;
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            issue(rand_instr(), 1'(($urandom_range(0, 1))), g);
        end

        instr_valid = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
